lte_ul_tdl_check: RTL
=====================

Name: lte_ul_tdl_check

Overview:
- Receive-side checker for TDL test patterns on the 30-bit I/Q datapath: the companion to the DL test-pattern inserter.
- Regenerates the expected word (constant I/Q or incrementing sgn/chip/cycle pattern) from its own frame-aligned counters.
- Compares it against the incoming stream inside a programmable chip window; reports error/check counts and first-error capture to the register map.
- Sits at the far end of the datapath under test, ahead of register readback.

Parameters:
- P_HDR_LAT, 2, cycles from i_fram_hd pulse to the data word carrying cycle 0 of chip 0 of symbol 0.
- P_CYC_MAX, 191, last value of the cycle counter per chip.
- P_CHIP_MAX, 31, last value of the chip counter per symbol.
- P_SGN_MAX, 199, last value of the symbol counter per frame.

Ports:
- clk_245  in  1  datapath clock.
- asy_rst  in  1  reset, asynchronous, active-high.
- i_fram_hd  in  1  frame header pulse, one cycle.
- i_ant8_sel  in  1  antenna-group marker; passed through only, not checked.
- i_data  in  30  {I[14:0],Q[14:0]} word under test.
- i_data_valid  in  1  word qualifier.
- reg_chk_mode  in  2  0 off, 1 constant, 2 increment, 3 reserved (treated as 0).
- reg_const_i  in  15  expected I in constant mode.
- reg_const_q  in  15  expected Q in constant mode.
- reg_win_start  in  16  first chip_num checked, inclusive.
- reg_win_end  in  16  last chip_num checked, inclusive.
- reg_clr  in  1  one-cycle pulse; clears all statistics.
- o_locked  out  1  checker aligned to a header and comparing.
- o_chk_cnt  out  32  words compared, saturating.
- o_err_cnt  out  32  mismatching words, saturating.
- o_hdr_slip_cnt  out  16  headers arriving off the expected frame boundary, saturating.
- o_first_err_chip  out  16  chip_num of the first error since clear.
- o_first_err_data  out  30  received word at the first error.
- o_sticky_err  out  1  set on any error, cleared by reg_clr.

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0.
- Delayed header hd_dly: i_fram_hd through a P_HDR_LAT-stage shift register.
- Local counters:
  - On hd_dly, cyc, chip and sgn all go to 0.
  - Otherwise cyc wraps at P_CYC_MAX; chip increments when cyc wraps (5-bit natural wrap); sgn increments when chip=P_CHIP_MAX and cyc wraps, wrapping at P_SGN_MAX.
  - chip_num = {3'b0,sgn,chip}, taken from the same cycle's counters.
- Expected word:
  - mode 1: {reg_const_i,reg_const_q}.
  - mode 2: {2'b0,sgn,3'b0,chip,4'b0,cyc}.
- FSM:
  - IDLE: mode 0/3. Entering IDLE drops o_locked; statistics are held.
  - WAIT_HDR: mode 1/2; waiting for hd_dly.
  - CHECK: entered on hd_dly; o_locked=1 from the next cycle.
  - Any mode change (including 1↔2) returns to IDLE the following cycle, then to WAIT_HDR.
- Compare qualification: state CHECK, i_data_valid=1, and reg_win_start <= chip_num <= reg_win_end (unsigned). A window with start>end never compares.
- Compare pipeline:
  - Stage 1 registers the match flag, chip_num and i_data.
  - Stage 2 updates the counters.
  - Latency from i_data to o_err_cnt: 2 cycles.
- First-error capture: loaded only while o_sticky_err=0. It is frozen until reg_clr.
- Header slip:
  - In CHECK, hd_dly arriving when the counters are not at the frame end (cyc=P_CYC_MAX, chip=P_CHIP_MAX, sgn=P_SGN_MAX) increments o_hdr_slip_cnt and realigns the counters.
  - The FSM stays in CHECK.
  - The word coincident with a slipping header is still compared against the realigned value, i.e. cycle 0.
- Saturation: counters hold at all-ones.
- reg_clr:
  - Clears the counters, first-error capture and sticky flag on the next edge.
  - If reg_clr coincides with a stage-2 update, clear wins and that update is lost.
  - Does not affect the FSM or lock.
- Asynchronous reset mid-frame: everything returns to reset values; lock is reacquired only on the next hd_dly.

Decomposition:
- Shared package lte_tdl_pkg:
  - mode encodings (TDL_CHK_OFF/CONST/INC).
  - P_CYC_MAX, P_CHIP_MAX, P_SGN_MAX.
  - function building the increment word from {sgn,chip,cyc}; the DL inserter reuses it.
- One sub-module, lte_tdl_frame_cnt: cyc/chip/sgn counters, chip_num output, end-of-frame flag. It is shareable with the DL side.

Test Plan:
- Mode 2, ideal increment stream aligned to a header delayed by 2, window 0..0xFFFF, one frame → o_chk_cnt=1,228,800, o_err_cnt=0, o_locked=1.
- Mode 1, const I=0x1234, Q=0x0ABC, window 32..63, one word in chip_num 40 forced to 0 → o_err_cnt=1, o_first_err_chip=40, o_first_err_data=forced word, o_sticky_err=1.
- Extra header injected at sgn 5 → o_hdr_slip_cnt=1; the following pattern restarted at 0 checks clean.
- i_data_valid low on alternate cycles over one chip in window → o_chk_cnt +96.
- reg_clr on the same cycle as a stage-2 error → o_err_cnt=0, sticky 0; the next error counts as 1 and is captured.
- Mode switched 2→0 mid-frame → o_locked=0 next cycle, counts frozen; mode back to 2 → relock only after the next header.

Source files
------------

// File: rtl/lte_tdl_pkg.sv
// Shared TDL test-pattern definitions used by both the DL inserter and the UL checker.
package lte_tdl_pkg;

  typedef enum logic [1:0] {
    TDL_CHK_OFF   = 2'd0,
    TDL_CHK_CONST = 2'd1,
    TDL_CHK_INC   = 2'd2
  } tdl_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_HDR = 2'd1,
    ST_CHECK    = 2'd2
  } chk_state_e;

  localparam int unsigned TDL_CYC_MAX  = 191;
  localparam int unsigned TDL_CHIP_MAX = 31;
  localparam int unsigned TDL_SGN_MAX  = 199;

  function automatic logic [29:0] tdl_inc_word(input logic [7:0] sgn,
                                                input logic [4:0] chip,
                                                input logic [7:0] cyc);
    return {2'b00, sgn, 3'b000, chip, 4'b0000, cyc};
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lte_tdl_frame_cnt.sv
// Frame-aligned cycle/chip/symbol counters; the registers hold the position of the
// previous word so a header can be judged against the true end of frame.
module lte_tdl_frame_cnt
  import lte_tdl_pkg::*;
#(
  parameter int unsigned P_CYC_MAX  = TDL_CYC_MAX,
  parameter int unsigned P_CHIP_MAX = TDL_CHIP_MAX,
  parameter int unsigned P_SGN_MAX  = TDL_SGN_MAX
) (
  input  logic        clk_245,
  input  logic        asy_rst,
  input  logic        i_sync,
  output logic [7:0]  o_cyc,
  output logic [4:0]  o_chip,
  output logic [7:0]  o_sgn,
  output logic [15:0] o_chip_num,
  output logic        o_at_eof
);

  logic [7:0] cyc_q, cyc_d, cyc_nxt;
  logic [4:0] chip_q, chip_d, chip_nxt;
  logic [7:0] sgn_q, sgn_d, sgn_nxt;
  logic       cyc_wrap, chip_wrap;

  always_comb begin
    cyc_wrap  = (cyc_q == 8'(P_CYC_MAX));
    chip_wrap = (chip_q == 5'(P_CHIP_MAX));
    cyc_nxt   = cyc_wrap ? 8'd0 : cyc_q + 8'd1;
    chip_nxt  = chip_q;
    sgn_nxt   = sgn_q;
    if (cyc_wrap) begin
      chip_nxt = chip_wrap ? 5'd0 : chip_q + 5'd1;
      if (chip_wrap) begin
        sgn_nxt = (sgn_q == 8'(P_SGN_MAX)) ? 8'd0 : sgn_q + 8'd1;
      end else begin
        sgn_nxt = sgn_q;
      end
    end else begin
      chip_nxt = chip_q;
    end
    // A sync pulse makes the current word position 0 of the frame.
    if (i_sync) begin
      cyc_d  = 8'd0;
      chip_d = 5'd0;
      sgn_d  = 8'd0;
    end else begin
      cyc_d  = cyc_nxt;
      chip_d = chip_nxt;
      sgn_d  = sgn_nxt;
    end
  end

  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      cyc_q  <= 8'd0;
      chip_q <= 5'd0;
      sgn_q  <= 8'd0;
    end else begin
      cyc_q  <= cyc_d;
      chip_q <= chip_d;
      sgn_q  <= sgn_d;
    end
  end

  assign o_cyc      = cyc_d;
  assign o_chip     = chip_d;
  assign o_sgn      = sgn_d;
  assign o_chip_num = {3'b000, sgn_d, chip_d};
  assign o_at_eof   = cyc_wrap && chip_wrap && (sgn_q == 8'(P_SGN_MAX));

endmodule

// File: rtl/lte_ul_tdl_check.sv
// UL TDL pattern checker: regenerates the expected word from frame counters and
// accumulates compare/error/slip statistics with first-error capture.
module lte_ul_tdl_check
  import lte_tdl_pkg::*;
#(
  parameter int unsigned P_HDR_LAT  = 2,
  parameter int unsigned P_CYC_MAX  = TDL_CYC_MAX,
  parameter int unsigned P_CHIP_MAX = TDL_CHIP_MAX,
  parameter int unsigned P_SGN_MAX  = TDL_SGN_MAX
) (
  input  logic        clk_245,
  input  logic        asy_rst,
  input  logic        i_fram_hd,
  input  logic        i_ant8_sel,
  input  logic [29:0] i_data,
  input  logic        i_data_valid,
  input  logic [1:0]  reg_chk_mode,
  input  logic [14:0] reg_const_i,
  input  logic [14:0] reg_const_q,
  input  logic [15:0] reg_win_start,
  input  logic [15:0] reg_win_end,
  input  logic        reg_clr,
  output logic        o_locked,
  output logic [31:0] o_chk_cnt,
  output logic [31:0] o_err_cnt,
  output logic [15:0] o_hdr_slip_cnt,
  output logic [15:0] o_first_err_chip,
  output logic [29:0] o_first_err_data,
  output logic        o_sticky_err
);

  logic [P_HDR_LAT-1:0] hd_sr_q, hd_sr_d;
  logic                 hd_dly;
  logic [7:0]           cyc, sgn;
  logic [4:0]           chip;
  logic [15:0]          chip_num;
  logic                 at_eof;
  tdl_mode_e            mode_eff, mode_q, mode_d;
  chk_state_e           state_q, state_d;
  logic                 locked_q, locked_d;
  logic [29:0]          exp_word;
  logic                 cmp_en, slip;
  logic                 s1_vld_q, s1_vld_d, s1_mis_q, s1_mis_d;
  logic [15:0]          s1_chip_q, s1_chip_d;
  logic [29:0]          s1_data_q, s1_data_d;
  logic [31:0]          chk_cnt_q, chk_cnt_d, err_cnt_q, err_cnt_d;
  logic [15:0]          slip_cnt_q, slip_cnt_d, first_chip_q, first_chip_d;
  logic [29:0]          first_data_q, first_data_d;
  logic                 sticky_q, sticky_d;
  logic                 unused_ant8;

  // Antenna-group marker travels alongside the data but is not part of the check.
  assign unused_ant8 = i_ant8_sel;

  always_comb begin
    hd_sr_d    = hd_sr_q << 1;
    hd_sr_d[0] = i_fram_hd;
  end
  assign hd_dly = hd_sr_q[P_HDR_LAT-1];

  lte_tdl_frame_cnt #(
    .P_CYC_MAX (P_CYC_MAX),
    .P_CHIP_MAX(P_CHIP_MAX),
    .P_SGN_MAX (P_SGN_MAX)
  ) u_frame_cnt (
    .clk_245   (clk_245),
    .asy_rst   (asy_rst),
    .i_sync    (hd_dly),
    .o_cyc     (cyc),
    .o_chip    (chip),
    .o_sgn     (sgn),
    .o_chip_num(chip_num),
    .o_at_eof  (at_eof)
  );

  always_comb begin
    case (reg_chk_mode)
      2'd1:    mode_eff = TDL_CHK_CONST;
      2'd2:    mode_eff = TDL_CHK_INC;
      default: mode_eff = TDL_CHK_OFF;
    endcase
  end

  // Any mode change, even between two active modes, forces a fresh alignment.
  always_comb begin
    mode_d  = mode_eff;
    state_d = state_q;
    if (mode_eff != mode_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = (mode_eff != TDL_CHK_OFF) ? ST_WAIT_HDR : ST_IDLE;
        ST_WAIT_HDR: state_d = hd_dly ? ST_CHECK : ST_WAIT_HDR;
        ST_CHECK:    state_d = ST_CHECK;
        default:     state_d = ST_IDLE;
      endcase
    end
    locked_d = (state_d == ST_CHECK);
  end

  always_comb begin
    if (mode_q == TDL_CHK_CONST) begin
      exp_word = {reg_const_i, reg_const_q};
    end else begin
      exp_word = tdl_inc_word(sgn, chip, cyc);
    end
    cmp_en    = (state_q == ST_CHECK) && i_data_valid &&
                (chip_num >= reg_win_start) && (chip_num <= reg_win_end);
    slip      = (state_q == ST_CHECK) && hd_dly && !at_eof;
    s1_vld_d  = cmp_en;
    s1_mis_d  = (i_data != exp_word);
    s1_chip_d = chip_num;
    s1_data_d = i_data;
  end

  // Clear takes priority over a stage-2 update landing on the same edge.
  always_comb begin
    chk_cnt_d    = chk_cnt_q;
    err_cnt_d    = err_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    first_chip_d = first_chip_q;
    first_data_d = first_data_q;
    sticky_d     = sticky_q;
    if (reg_clr) begin
      chk_cnt_d    = 32'd0;
      err_cnt_d    = 32'd0;
      slip_cnt_d   = 16'd0;
      first_chip_d = 16'd0;
      first_data_d = 30'd0;
      sticky_d     = 1'b0;
    end else begin
      slip_cnt_d = slip ? sat_inc16(slip_cnt_q) : slip_cnt_q;
      if (s1_vld_q) begin
        chk_cnt_d = sat_inc32(chk_cnt_q);
        if (s1_mis_q) begin
          err_cnt_d = sat_inc32(err_cnt_q);
          sticky_d  = 1'b1;
          if (!sticky_q) begin
            first_chip_d = s1_chip_q;
            first_data_d = s1_data_q;
          end else begin
            first_chip_d = first_chip_q;
            first_data_d = first_data_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end else begin
        chk_cnt_d = chk_cnt_q;
      end
    end
  end

  always_ff @(posedge clk_245 or posedge asy_rst) begin
    if (asy_rst) begin
      hd_sr_q      <= '0;
      mode_q       <= TDL_CHK_OFF;
      state_q      <= ST_IDLE;
      locked_q     <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_mis_q     <= 1'b0;
      s1_chip_q    <= 16'd0;
      s1_data_q    <= 30'd0;
      chk_cnt_q    <= 32'd0;
      err_cnt_q    <= 32'd0;
      slip_cnt_q   <= 16'd0;
      first_chip_q <= 16'd0;
      first_data_q <= 30'd0;
      sticky_q     <= 1'b0;
    end else begin
      hd_sr_q      <= hd_sr_d;
      mode_q       <= mode_d;
      state_q      <= state_d;
      locked_q     <= locked_d;
      s1_vld_q     <= s1_vld_d;
      s1_mis_q     <= s1_mis_d;
      s1_chip_q    <= s1_chip_d;
      s1_data_q    <= s1_data_d;
      chk_cnt_q    <= chk_cnt_d;
      err_cnt_q    <= err_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      first_chip_q <= first_chip_d;
      first_data_q <= first_data_d;
      sticky_q     <= sticky_d;
    end
  end

  assign o_locked         = locked_q;
  assign o_chk_cnt        = chk_cnt_q;
  assign o_err_cnt        = err_cnt_q;
  assign o_hdr_slip_cnt   = slip_cnt_q;
  assign o_first_err_chip = first_chip_q;
  assign o_first_err_data = first_data_q;
  assign o_sticky_err     = sticky_q;

endmodule
